rlbp_wb_loader: RTL
===================

Name: rlbp_wb_loader

Overview:
- Wishbone master (initiator) that programs the RLBP timing-register block over its Wishbone slave port, one register per bus cycle.
- On a start pulse it snapshots a 16-entry configuration image and writes it to BASE_ADDR + 4*i, for i = 0..NUM_REGS-1.
- It can optionally read every register back and compare it against the snapshot.
- It lets the analog test sequence be configured from LA/host logic without the CPU driving individual bus transactions.

Parameters:
- BASE_ADDR, 32'h3000_0000: address of register 0. The slave decodes adr[31:28]==3 and adr[7:0].
- NUM_REGS, 16: number of registers to program (1..16).
- DW, 12: significant data bits per register. Bits 31:DW are written as 0 and ignored on compare.
- TIMEOUT, 255: maximum cycles to wait for wbm_ack_i per transfer (1..255).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start request; ignored while busy_o=1.
- verify_i  in  1  sampled with start_i; 1 enables the readback pass.
- cfg_i  in  NUM_REGS*DW  configuration image; entry i is cfg_i[i*DW +: DW].
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe; always equal to wbm_cyc_o.
- wbm_we_o  out  1  1 = write.
- wbm_sel_o  out  4  4'hF on writes, 4'h0 on reads.
- wbm_adr_o  out  32  BASE_ADDR + 4*idx.
- wbm_dat_o  out  32  zero-extended snapshot entry.
- wbm_dat_i  in  32  read data, valid when wbm_ack_i=1.
- wbm_ack_i  in  1  slave acknowledge.
- busy_o  out  1  high from the cycle after start is accepted until DONE/ERR is entered.
- done_o  out  1  one-cycle pulse on completion (success or error).
- timeout_o  out  1  sticky: last run aborted on a missing ack.
- mismatch_o  out  1  sticky: readback differed from the snapshot.
- err_idx_o  out  4  index of the first mismatching or timed-out register.

Behaviour:
- Reset (asynchronous, wb_rst_ni=0): every output is 0, the FSM is in IDLE, idx=0 and the timeout counter is 0. Reset asserted mid-transfer drops cyc/stb immediately; no completion pulse follows.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN.
- IDLE, start_i=1:
  - snapshot cfg_i and verify_i;
  - clear timeout_o, mismatch_o and err_idx_o;
  - set idx=0 and go to WR_REQ.
- WR_REQ: cyc=stb=we=1, sel=4'hF, adr/dat driven from idx.
  - On wbm_ack_i=1, deassert cyc/stb on the next edge and go to WR_GAP.
- WR_GAP: bus idle for exactly 1 cycle. The slave acks one cycle after a valid request and would re-ack a held strobe, so this gap is mandatory.
  - Then: if idx==NUM_REGS-1, go to RD_REQ with idx=0 when verify is set, otherwise to FIN.
  - Else idx++ and go to WR_REQ.
- RD_REQ: cyc=stb=1, we=0, sel=4'h0.
  - On ack, compare wbm_dat_i[DW-1:0] with the snapshot entry.
  - On the first mismatch, set mismatch_o and latch err_idx_o=idx. Later mismatches do not change err_idx_o. The pass continues through all entries.
  - Then go to RD_GAP.
- RD_GAP: 1 idle cycle. Same idx handling as WR_GAP, then RD_REQ or FIN.
- Timeout:
  - The counter resets on entry to each *_REQ state and increments every cycle without ack.
  - When the counter reaches TIMEOUT: set timeout_o, latch err_idx_o=idx (overriding any mismatch index), drop the bus and go to FIN.
  - An ack arriving in that same cycle takes priority over the timeout.
- FIN: done_o=1 and busy_o=0 for one cycle, then IDLE.
- Latency: minimum per transfer is 3 cycles (REQ, ack cycle, GAP).
  - NUM_REGS=16 with a 1-cycle-ack slave: write pass = 48 cycles; with verify = 96 cycles, plus 1 cycle for FIN.
- start_i while not in IDLE is ignored. cfg_i changes after start have no effect.
- Outputs wbm_* and done_o are registered.

Decomposition:
- Package rlbp_pkg:
  - FSM state encoding;
  - register offset constants TIME_UP_1..TIME_CMP (0..60 step 4), shared with the slave block;
  - RLBP_DW=12.
- One natural sub-module: rlbp_wb_timeout, a loadable down-counter with an expiry flag.

Test Plan:
- Slave model acking 1 cycle after stb, verify=0, cfg entry i = 12'h100+i:
  - 16 writes at adr 0x3000_0000..0x3000_003C with dat 0x100..0x10F;
  - cyc low for 1 cycle between transfers;
  - done_o at cycle 49; timeout_o=0.
- verify=1, model returns the stored values: 16 reads follow the writes with sel=0, mismatch_o=0, done_o after 97 cycles.
- verify=1, model corrupts the readback of reg 5 (returns 12'hFFF) and reg 9: mismatch_o=1, err_idx_o=5, all 16 reads still issued.
- Model never acks reg 3, TIMEOUT=255:
  - stb held for 255 cycles, then cyc drops;
  - timeout_o=1, err_idx_o=3, done_o pulses, regs 4..15 never addressed.
- start_i pulsed again mid-run and cfg_i changed after start: no restart; written data equals the original snapshot.
- wb_rst_ni pulled low during write 7:
  - cyc/stb/busy go 0 asynchronously (before the next clock edge);
  - no done_o pulse;
  - after release, start runs a full sequence from idx 0.

Source files
------------

// File: rtl/rlbp_pkg.sv
// Shared definitions for the RLBP timing-register block and its Wishbone loader:
// loader FSM encoding, register byte offsets and the register data width.
package rlbp_pkg;

  localparam int RLBP_DW = 12;

  localparam logic [7:0] TIME_UP_1 = 8'h00;
  localparam logic [7:0] TIME_UP_2 = 8'h04;
  localparam logic [7:0] TIME_UP_3 = 8'h08;
  localparam logic [7:0] TIME_UP_4 = 8'h0C;
  localparam logic [7:0] TIME_DN_1 = 8'h10;
  localparam logic [7:0] TIME_DN_2 = 8'h14;
  localparam logic [7:0] TIME_DN_3 = 8'h18;
  localparam logic [7:0] TIME_DN_4 = 8'h1C;
  localparam logic [7:0] TIME_RST  = 8'h20;
  localparam logic [7:0] TIME_PRE  = 8'h24;
  localparam logic [7:0] TIME_SMP  = 8'h28;
  localparam logic [7:0] TIME_HOLD = 8'h2C;
  localparam logic [7:0] TIME_INT  = 8'h30;
  localparam logic [7:0] TIME_RD   = 8'h34;
  localparam logic [7:0] TIME_SETL = 8'h38;
  localparam logic [7:0] TIME_CMP  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_FIN
  } loader_state_t;

  // Registers sit on a 4-byte stride starting at offset 0.
  function automatic logic [31:0] reg_byte_offset(input logic [3:0] idx);
    return {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/rlbp_wb_timeout.sv
// Per-transfer ack watchdog: loadable down-counter that flags the last cycle
// a request may wait before it is abandoned.
module rlbp_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= 8'(TIMEOUT);
    end else if (i_en && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // At 1 the coming edge would complete the TIMEOUT-th cycle without ack.
  assign o_expired = (r_cnt == 8'd1);

endmodule

// File: rtl/rlbp_wb_loader.sv
// Wishbone initiator that snapshots a configuration image and programs it into
// the RLBP timing registers, optionally reading every register back to verify.
module rlbp_wb_loader
  import rlbp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_REGS  = 16,
  parameter int          DW        = RLBP_DW,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   start_i,
  input  logic                   verify_i,
  input  logic [NUM_REGS*DW-1:0] cfg_i,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic                   wbm_we_o,
  output logic [3:0]             wbm_sel_o,
  output logic [31:0]            wbm_adr_o,
  output logic [31:0]            wbm_dat_o,
  input  logic [31:0]            wbm_dat_i,
  input  logic                   wbm_ack_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic                   mismatch_o,
  output logic [3:0]             err_idx_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  loader_state_t         r_state, w_next_state;
  logic [3:0]            r_idx, w_next_idx;
  logic                  r_verify;
  logic [NUM_REGS*DW-1:0] r_snap, w_snap_src;
  logic [DW-1:0]         w_cur_entry, w_next_entry;
  logic                  w_start, w_set_timeout, w_rd_bad;
  logic                  w_in_req, w_next_req, w_tmo_load, w_tmo_en, w_expired;
  logic                  r_cyc, r_we, r_busy, r_done, r_timeout, r_mismatch;
  logic [3:0]            r_sel, r_err_idx;
  logic [31:0]           r_adr, r_dat;
  logic                  w_unused_dat;

  assign w_unused_dat = ^wbm_dat_i[31:DW];

  // The bus outputs are registered from next-state, so the entry being launched
  // on the start edge must come straight from cfg_i.
  assign w_snap_src   = w_start ? cfg_i : r_snap;
  assign w_cur_entry  = r_snap[r_idx*DW +: DW];
  assign w_next_entry = w_snap_src[w_next_idx*DW +: DW];

  assign w_in_req   = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
  assign w_next_req = (w_next_state == ST_WR_REQ) || (w_next_state == ST_RD_REQ);
  assign w_tmo_load = w_next_req && (w_next_state != r_state);
  assign w_tmo_en   = w_in_req && !wbm_ack_i;

  rlbp_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .i_load    (w_tmo_load),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_start       = 1'b0;
    w_set_timeout = 1'b0;
    w_rd_bad      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_start      = 1'b1;
          w_next_idx   = '0;
          w_next_state = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (wbm_ack_i) begin
          w_next_state = ST_WR_GAP;
        end else if (w_expired) begin
          w_set_timeout = 1'b1;
          w_next_state  = ST_FIN;
        end
      end
      ST_WR_GAP: begin
        if (r_idx == LAST_IDX) begin
          w_next_idx   = '0;
          w_next_state = r_verify ? ST_RD_REQ : ST_FIN;
        end else begin
          w_next_idx   = r_idx + 4'd1;
          w_next_state = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (wbm_ack_i) begin
          w_rd_bad     = (wbm_dat_i[DW-1:0] != w_cur_entry);
          w_next_state = ST_RD_GAP;
        end else if (w_expired) begin
          w_set_timeout = 1'b1;
          w_next_state  = ST_FIN;
        end
      end
      ST_RD_GAP: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = ST_FIN;
        end else begin
          w_next_idx   = r_idx + 4'd1;
          w_next_state = ST_RD_REQ;
        end
      end
      ST_FIN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_verify <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      if (w_start) r_verify <= verify_i;
    end
  end

  // NOTE: the snapshot is pure data qualified by the FSM, so it carries no reset.
  always_ff @(posedge wb_clk_i) begin
    if (w_start) r_snap <= cfg_i;
  end

  // A timeout index always overrides an earlier mismatch index.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_timeout  <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_idx  <= '0;
    end else if (w_start) begin
      r_timeout  <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_idx  <= '0;
    end else if (w_set_timeout) begin
      r_timeout <= 1'b1;
      r_err_idx <= r_idx;
    end else if (w_rd_bad) begin
      r_mismatch <= 1'b1;
      if (!r_mismatch) r_err_idx <= r_idx;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cyc  <= w_next_req;
      r_we   <= (w_next_state == ST_WR_REQ);
      r_sel  <= (w_next_state == ST_WR_REQ) ? 4'hF : 4'h0;
      r_adr  <= w_next_req ? (BASE_ADDR + reg_byte_offset(w_next_idx)) : '0;
      r_dat  <= w_next_req ? 32'(w_next_entry) : '0;
      r_busy <= (w_next_state != ST_IDLE) && (w_next_state != ST_FIN);
      r_done <= (w_next_state == ST_FIN);
    end
  end

  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
  assign wbm_we_o   = r_we;
  assign wbm_sel_o  = r_sel;
  assign wbm_adr_o  = r_adr;
  assign wbm_dat_o  = r_dat;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign timeout_o  = r_timeout;
  assign mismatch_o = r_mismatch;
  assign err_idx_o  = r_err_idx;

endmodule
